// File: rtl/i2s_pkg.sv
// Shared I2S types and sizing helpers for the transmit path.
package i2s_pkg;

    localparam int unsigned I2S_WIDTH = 16;

    typedef logic signed [I2S_WIDTH-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } frame_t;

    function automatic int unsigned bitcnt_w(input int unsigned width);
        return $clog2(2 * width);
    endfunction

    localparam int unsigned BITCNT_W = bitcnt_w(I2S_WIDTH);

endpackage

// File: rtl/i2s_sclk_gen.sv
// Bit-clock divider: toggles sclk every SCLK_HALF clocks while enabled and
// flags the clock cycle on which each rise/fall takes effect.
module i2s_sclk_gen #(
    parameter int unsigned SCLK_HALF = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned DivW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCLK_HALF - 1);

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic            sclk_q, sclk_d;
    logic            wrap;

    always_comb begin
        wrap      = en_i && (div_cnt_q == DivLast);
        div_cnt_d = div_cnt_q;
        sclk_d    = sclk_q;
        if (!en_i) begin
            div_cnt_d = '0;
            sclk_d    = 1'b0;
        end else if (wrap) begin
            div_cnt_d = '0;
            sclk_d    = ~sclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
        // Strobes mark the edge at which sclk_q is about to change.
        rise_o = wrap && !sclk_q;
        fall_o = wrap && sclk_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: single-entry holding register in front of a frame
// shifter, outputs updated on sclk fall so the receiver samples on rise.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH     = I2S_WIDTH,
    parameter int unsigned SCLK_HALF = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] leftChan_i,
    input  logic [WIDTH-1:0] rightChan_i,
    input  logic             sampleValid_i,
    output logic             sampleReady_o,
    output logic             sclk_o,
    output logic             ws_o,
    output logic             sdata_o,
    output logic             frameStart_o,
    output logic             underrun_o
);

    localparam int unsigned FrameW = 2 * WIDTH;
    localparam int unsigned BitW   = bitcnt_w(WIDTH);
    localparam logic [BitW-1:0] LastBit   = BitW'(FrameW - 1);
    localparam logic [BitW-1:0] RightSlot = BitW'(WIDTH);
    localparam logic [BitW-1:0] LoadBit   = BitW'(1);

    logic              sclk_rise, sclk_fall;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d, nb;
    logic              hold_full_q, hold_full_d;
    logic [FrameW-1:0] hold_q, hold_d;
    logic [FrameW-1:0] shreg_q, shreg_d;
    logic              ws_q, ws_d;
    logic              sdata_q, sdata_d;
    logic              frame_start_q, frame_start_d;
    logic              underrun_q, underrun_d;
    logic              load_event, accept;

    i2s_sclk_gen #(
        .SCLK_HALF(SCLK_HALF)
    ) u_sclk_gen (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (en_i),
        .sclk_o(sclk_o),
        .rise_o(sclk_rise),
        .fall_o(sclk_fall)
    );

    always_comb begin
        nb            = (bit_cnt_q == LastBit) ? '0 : bit_cnt_q + 1'b1;
        load_event    = sclk_fall && (nb == LoadBit);
        sampleReady_o = !hold_full_q || load_event;
        accept        = sampleValid_i && sampleReady_o;

        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        ws_d          = ws_q;
        sdata_d       = sdata_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        // An accept on the load cycle wins: the old pair has just moved to shreg.
        if (accept) begin
            hold_d      = {leftChan_i, rightChan_i};
            hold_full_d = 1'b1;
        end else if (load_event) begin
            hold_full_d = 1'b0;
        end

        if (!en_i) begin
            bit_cnt_d = LastBit;
            shreg_d   = '0;
            ws_d      = 1'b1;
            sdata_d   = 1'b0;
        end else if (sclk_fall) begin
            bit_cnt_d = nb;
            ws_d      = (nb >= RightSlot);
            if (nb == LoadBit) begin
                frame_start_d = 1'b1;
                if (hold_full_q) begin
                    sdata_d = hold_q[FrameW-1];
                    shreg_d = {hold_q[FrameW-2:0], 1'b0};
                end else begin
                    underrun_d = 1'b1;
                    sdata_d    = 1'b0;
                    shreg_d    = '0;
                end
            end else begin
                sdata_d = shreg_q[FrameW-1];
                shreg_d = {shreg_q[FrameW-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            bit_cnt_q     <= LastBit;
            shreg_q       <= '0;
            ws_q          <= 1'b1;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            ws_q          <= ws_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign ws_o         = ws_q;
    assign sdata_o      = sdata_q;
    assign frameStart_o = frame_start_q;
    assign underrun_o   = underrun_q;

    sclk_edges_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        !(sclk_rise && sclk_fall));

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: stimulus table and random stream feed a scoreboard that a
// behavioural I2S receiver (sampling on sclk rise) drains in order.
module tb_i2s_tx;
    import i2s_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned SH = 2;

    logic         clk = 1'b0;
    logic         rst, en, valid;
    logic [W-1:0] left, right;
    logic         ready, sclk, ws, sdata, fstart, urun;

    i2s_tx #(
        .WIDTH    (W),
        .SCLK_HALF(SH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .leftChan_i   (left),
        .rightChan_i  (right),
        .sampleValid_i(valid),
        .sampleReady_o(ready),
        .sclk_o       (sclk),
        .ws_o         (ws),
        .sdata_o      (sdata),
        .frameStart_o (fstart),
        .underrun_o   (urun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        frame_t       exp;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0, fs_cnt = 0, ur_cnt = 0, fs_last = 0, fs_gap = 0, zero_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Receiver: a ws 1->0 seen on a rise closes a frame (that bit is the right LSB).
    initial begin
        logic        sclk_prev = 1'b0;
        logic        ws_prev = 1'b1;
        logic [31:0] rx_sr = '0;
        int          nbits = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (fstart) begin
                fs_cnt++;
                fs_gap  = cyc - fs_last;
                fs_last = cyc;
            end
            if (urun) ur_cnt++;
            if (rst || !en) begin
                ws_prev = 1'b1;
                nbits   = 0;
            end else if (sclk && !sclk_prev) begin
                rx_sr = {rx_sr[30:0], sdata};
                nbits++;
                if (ws_prev && !ws) begin
                    if (nbits == 32) begin
                        if (rx_sr == 32'h0) zero_frames++;
                        else if (sb.size() == 0) check("rx_unexpected", rx_sr, 32'h0);
                        else check("rx_frame", rx_sr, sb.pop_front());
                    end
                    nbits = 0;
                end
                ws_prev = ws;
            end
            sclk_prev = sclk;
        end
    end

    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r, input logic [31:0] e);
        logic ok = 1'b0;
        left  = l;
        right = r;
        valid = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if (ready) begin
                @(posedge clk);
                sb.push_back(e);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1 valid = 1'b0;
        check("send_accepted", 32'(ok), 32'h1);
    endtask

    task automatic drain(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("drain_empty", sb.size(), 32'h0);
    endtask

    task automatic wait_fs(input int bound);
        logic seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (fstart) begin
                seen = 1'b1;
                break;
            end
        end
        check("frame_start_seen", 32'(seen), 32'h1);
    endtask

    initial begin
        int n, fs0, ur0;
        logic [W-1:0] rl, rr;

        vecs[0] = '{16'hA5F0, 16'h0F0F, 32'hA5F0_0F0F};
        vecs[1] = '{16'h0001, 16'h8000, 32'h0001_8000};
        vecs[2] = '{16'h7FFF, 16'hFFFF, 32'h7FFF_FFFF};
        vecs[3] = '{16'h1234, 16'h5678, 32'h1234_5678};
        vecs[4] = '{16'h8000, 16'h0001, 32'h8000_0001};
        vecs[5] = '{16'hFFFF, 16'h0000, 32'hFFFF_0000};
        vecs[6] = '{16'h0000, 16'hFFFF, 32'h0000_FFFF};
        vecs[7] = '{16'h5555, 16'hAAAA, 32'h5555_AAAA};

        rst = 1'b1; en = 1'b0; valid = 1'b0; left = '0; right = '0;
        #12;
        check("rst_sclk", 32'(sclk), 32'h0);
        check("rst_ws", 32'(ws), 32'h1);
        check("rst_sdata", 32'(sdata), 32'h0);
        check("rst_fstart", 32'(fstart), 32'h0);
        check("rst_urun", 32'(urun), 32'h0);
        check("rst_ready", 32'(ready), 32'h1);
        @(negedge clk) rst = 1'b0;

        // Async reset mid-frame with the holding register full.
        send(vecs[7].l, vecs[7].r, vecs[7].exp);
        check("idle_hold_full_ready", 32'(ready), 32'h0);
        en = 1'b1;
        n = 0;
        while (!(sclk && !ws) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midframe_reached", 32'(n < 100), 32'h1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_sclk", 32'(sclk), 32'h0);
        check("arst_ws", 32'(ws), 32'h1);
        check("arst_sdata", 32'(sdata), 32'h0);
        check("arst_ready", 32'(ready), 32'h1);
        sb.delete();
        @(negedge clk) rst = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 n++;
            if (sclk) break;
        end
        check("first_rise_clks", n, 32'd2);

        // Single pair then starvation: next frame underruns, 128 clk period.
        fs0 = fs_cnt;
        ur0 = ur_cnt;
        send(vecs[0].l, vecs[0].r, vecs[0].exp);
        for (int k = 0; k < 400 && fs_cnt < fs0 + 2; k++) @(negedge clk);
        check("two_frames_started", fs_cnt - fs0, 32'd2);
        check("frame_period", fs_gap, 32'd128);
        check("underrun_once", ur_cnt - ur0, 32'd1);
        drain(400);

        // Back-to-back pair; the second accept lands on the load cycle.
        wait_fs(200);
        repeat (10) @(negedge clk);
        send(vecs[1].l, vecs[1].r, vecs[1].exp);
        ur0 = ur_cnt;
        check("ready_after_accept", 32'(ready), 32'h0);
        send(vecs[2].l, vecs[2].r, vecs[2].exp);
        check("accept_on_load_fstart", 32'(fstart), 32'h1);
        check("accept_on_load_urun", 32'(urun), 32'h0);
        check("accept_on_load_ready", 32'(ready), 32'h0);
        drain(600);
        check("stream_no_underrun", ur_cnt - ur0, 32'd0);

        // Remaining table vectors streamed back to back.
        ur0 = ur_cnt;
        for (int i = 3; i < 8; i++) send(vecs[i].l, vecs[i].r, vecs[i].exp);
        drain(600);
        check("table_no_underrun", ur_cnt - ur0, 32'd0);

        // Disable mid-left-word with a pair pending, then restart.
        wait_fs(200);
        repeat (10) @(negedge clk);
        send(vecs[6].l, vecs[6].r, vecs[6].exp);
        wait_fs(200);
        send(vecs[3].l, vecs[3].r, vecs[3].exp);
        repeat (24) @(negedge clk);
        en = 1'b0;
        void'(sb.pop_front());
        @(negedge clk);
        check("dis_sclk", 32'(sclk), 32'h0);
        check("dis_ws", 32'(ws), 32'h1);
        check("dis_sdata", 32'(sdata), 32'h0);
        check("dis_hold_kept", 32'(ready), 32'h0);
        repeat (50) @(negedge clk);
        check("idle_sclk", 32'(sclk), 32'h0);
        check("idle_ws", 32'(ws), 32'h1);
        en = 1'b1;
        ur0 = ur_cnt;
        wait_fs(40);
        check("restart_no_urun", 32'(urun), 32'h0);
        drain(400);
        check("restart_urun_cnt", ur_cnt - ur0, 32'd0);

        // Random loopback stream.
        ur0 = ur_cnt;
        for (int i = 0; i < 100; i++) begin
            rl = W'($urandom_range(0, 65535));
            rr = W'($urandom_range(0, 65535));
            if (rl == 0 && rr == 0) rr = 16'h0001;
            send(rl, rr, {rl, rr});
        end
        drain(600);
        check("random_no_underrun", ur_cnt - ur0, 32'd0);
        check("scoreboard_empty", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
